// File: rtl/insn_seq_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control sequencer.
package insn_seq_pkg;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  // Bit positions of the one-hot instruction class code
  localparam int unsigned C_JAL    = 0;
  localparam int unsigned C_JALR   = 1;
  localparam int unsigned C_LUI    = 2;
  localparam int unsigned C_AUIPC  = 3;
  localparam int unsigned C_BRANCH = 4;
  localparam int unsigned C_RALU   = 5;
  localparam int unsigned C_STORE  = 6;
  localparam int unsigned C_IALU   = 7;
  localparam int unsigned C_LOAD   = 8;
  localparam int unsigned C_SYS    = 9;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SRX    = 3'b101;

endpackage

// File: rtl/insn_seq_if.sv
// Sequencer <-> datapath/memory signal bundle.
interface insn_seq_if #(
  parameter int unsigned CODE_W    = 10,
  parameter int unsigned RET_CNT_W = 32
);
  logic [31:0]          insn;
  logic [CODE_W-1:0]    code;
  logic                 EQ;
  logic                 LS;
  logic                 LU;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 addr_sel;
  logic                 insn_we;
  logic                 sub_sra;
  logic                 pc_alu_sel;
  logic                 pc_next_sel;
  logic                 pc_we;
  logic                 rd_we;
  logic                 mem_we;
  logic                 illegal;
  logic                 mem_timeout;
  logic [RET_CNT_W-1:0] retired;

  modport master (
    input  insn, code, EQ, LS, LU, mem_ready,
    output mem_req, addr_sel, insn_we, sub_sra, pc_alu_sel, pc_next_sel,
           pc_we, rd_we, mem_we, illegal, mem_timeout, retired
  );

  modport slave (
    output insn, code, EQ, LS, LU, mem_ready,
    input  mem_req, addr_sel, insn_we, sub_sra, pc_alu_sel, pc_next_sel,
           pc_we, rd_we, mem_we, illegal, mem_timeout, retired
  );
endinterface

// File: rtl/insn_class_decode.sv
// Combinational per-class controls: ALU sub/sra, PC operand/source, write-back and memory class.
module insn_class_decode
  import insn_seq_pkg::*;
#(
  parameter int unsigned CODE_W = 10
) (
  input  logic [2:0]        funct3,
  input  logic              alt,
  input  logic [CODE_W-1:0] code,
  input  logic              eq,
  input  logic              ls,
  input  logic              lu,
  output logic              sub_sra,
  output logic              pc_alu_sel,
  output logic              pc_next_sel,
  output logic              rd_class,
  output logic              mem_class,
  output logic              store_class
);

  logic taken;

  always_comb begin
    taken       = 1'b0;
    sub_sra     = 1'b0;
    pc_alu_sel  = 1'b0;
    pc_next_sel = code[C_JALR];
    rd_class    = code[C_JAL] | code[C_JALR] | code[C_LUI] | code[C_AUIPC] |
                  code[C_RALU] | code[C_IALU] | code[C_LOAD];
    mem_class   = code[C_LOAD] | code[C_STORE];
    store_class = code[C_STORE];

    // funct3 010/011 are not branches and fall through as not taken
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = ls;
      F3_BGE:  taken = ~ls;
      F3_BLTU: taken = lu;
      F3_BGEU: taken = ~lu;
      default: taken = 1'b0;
    endcase

    if (code[C_RALU]) begin
      sub_sra = alt & ((funct3 == F3_ADDSUB) | (funct3 == F3_SRX));
    end else if (code[C_IALU]) begin
      sub_sra = alt & (funct3 == F3_SRX);
    end else if (code[C_BRANCH]) begin
      sub_sra = 1'b1;
    end

    if (code[C_JAL]) begin
      pc_alu_sel = 1'b1;
    end else if (code[C_BRANCH]) begin
      pc_alu_sel = taken;
    end
  end

endmodule

// File: rtl/insn_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB control sequencer with memory wait timeout and retire counter.
module insn_sequencer
  import insn_seq_pkg::*;
#(
  parameter int unsigned CODE_W    = 10,
  parameter int unsigned WAIT_W    = 4,
  parameter int unsigned RET_CNT_W = 32
) (
  input logic        clk,
  input logic        rst_n,
  insn_seq_if.master bus
);

  // Last wait count before the counter would reach all-ones
  localparam logic [WAIT_W-1:0] WAIT_LIM = {{(WAIT_W-1){1'b1}}, 1'b0};

  state_e               state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 mem_req;
  logic                 addr_sel;
  logic                 mem_we;
  logic                 pc_we;
  logic                 rd_we;
  logic                 illegal;
  logic                 mem_timeout;
  logic [RET_CNT_W-1:0] retired;
  logic                 rd_class;
  logic                 mem_class;
  logic                 store_class;
  logic                 accept;
  logic                 stall;
  logic                 at_limit;

  insn_class_decode #(.CODE_W(CODE_W)) u_class_decode (
    .funct3      (bus.insn[14:12]),
    .alt         (bus.insn[30]),
    .code        (bus.code),
    .eq          (bus.EQ),
    .ls          (bus.LS),
    .lu          (bus.LU),
    .sub_sra     (bus.sub_sra),
    .pc_alu_sel  (bus.pc_alu_sel),
    .pc_next_sel (bus.pc_next_sel),
    .rd_class    (rd_class),
    .mem_class   (mem_class),
    .store_class (store_class)
  );

  assign accept   = mem_req & bus.mem_ready;
  assign stall    = mem_req & ~bus.mem_ready;
  assign at_limit = (wait_cnt == WAIT_LIM);

  // A request is only outstanding once mem_req is registered high, so the first FETCH after reset idles one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      addr_sel    <= 1'b0;
      mem_we      <= 1'b0;
      pc_we       <= 1'b0;
      rd_we       <= 1'b0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
      retired     <= '0;
    end else begin
      pc_we <= 1'b0;
      rd_we <= 1'b0;
      case (state)
        FETCH: begin
          mem_req  <= 1'b1;
          addr_sel <= 1'b0;
          mem_we   <= 1'b0;
          if (accept) begin
            state   <= EXEC;
            mem_req <= 1'b0;
          end else if (stall) begin
            if (at_limit) begin
              state       <= HALT;
              mem_timeout <= 1'b1;
              mem_req     <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
        end
        EXEC: begin
          if (!$onehot(bus.code)) begin
            state   <= HALT;
            illegal <= 1'b1;
          end else if (mem_class) begin
            state    <= MEM;
            mem_req  <= 1'b1;
            addr_sel <= 1'b1;
            mem_we   <= store_class;
            wait_cnt <= '0;
          end else begin
            state <= WB;
            pc_we <= 1'b1;
            rd_we <= rd_class;
          end
        end
        MEM: begin
          if (accept) begin
            state    <= WB;
            mem_req  <= 1'b0;
            addr_sel <= 1'b0;
            mem_we   <= 1'b0;
            pc_we    <= 1'b1;
            rd_we    <= rd_class;
          end else if (stall) begin
            if (at_limit) begin
              state       <= HALT;
              mem_timeout <= 1'b1;
              mem_req     <= 1'b0;
              addr_sel    <= 1'b0;
              mem_we      <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
        end
        WB: begin
          state    <= FETCH;
          retired  <= retired + RET_CNT_W'(1);
          mem_req  <= 1'b1;
          wait_cnt <= '0;
        end
        default: begin
          mem_req  <= 1'b0;
          addr_sel <= 1'b0;
          mem_we   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.insn_we     = (state == FETCH) & accept;
  assign bus.mem_req     = mem_req;
  assign bus.addr_sel    = addr_sel;
  assign bus.mem_we      = mem_we;
  assign bus.pc_we       = pc_we;
  assign bus.rd_we       = rd_we;
  assign bus.illegal     = illegal;
  assign bus.mem_timeout = mem_timeout;
  assign bus.retired     = retired;

endmodule

// File: tb/tb_insn_sequencer.sv
// Directed bench for insn_sequencer: class decode, memory waits, timeout, illegal halt, reset, retire wrap.
module tb_insn_sequencer;
  import insn_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  insn_seq_if #(.CODE_W(10), .RET_CNT_W(2)) bus ();

  insn_sequencer #(.CODE_W(10), .WAIT_W(4), .RET_CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.insn = '0;
    bus.code = '0;
    bus.EQ = 1'b0;
    bus.LS = 1'b0;
    bus.LU = 1'b0;
    exp_ret = '0;
    repeat (2) tick;
    check("rst/mem_req", 32'(bus.mem_req), 0);
    check("rst/addr_sel", 32'(bus.addr_sel), 0);
    check("rst/strobes", 32'({bus.insn_we, bus.pc_we, bus.rd_we, bus.mem_we}), 0);
    check("rst/sticky", 32'({bus.illegal, bus.mem_timeout}), 0);
    check("rst/retired", 32'(bus.retired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("rst/fetch_req", 32'(bus.mem_req), 1);
  endtask

  // Enter with FETCH requesting; leave in EXEC
  task automatic fetch(input int waits, input logic [31:0] w, input logic [9:0] c,
                       input logic eq, input logic ls, input logic lu);
    bus.mem_ready = 1'b0;
    repeat (waits) begin
      #1 check("fetch/wait_insn_we", 32'(bus.insn_we), 0);
      tick;
    end
    bus.insn = w;
    bus.code = c;
    bus.EQ = eq;
    bus.LS = ls;
    bus.LU = lu;
    bus.mem_ready = 1'b1;
    #1 check("fetch/insn_we", 32'(bus.insn_we), 1);
    tick;
    bus.mem_ready = 1'b0;
  endtask

  task automatic run_case(input string tag, input int waits, input logic [31:0] w, input int cbit,
                          input logic eq, input logic ls, input logic lu,
                          input logic e_sub, input logic e_alu, input logic e_nxt, input logic e_rd);
    logic [9:0] c;
    c = 10'(1) << cbit;
    fetch(waits, w, c, eq, ls, lu);
    check({tag, "/sub_sra"}, 32'(bus.sub_sra), 32'(e_sub));
    check({tag, "/pc_alu_sel"}, 32'(bus.pc_alu_sel), 32'(e_alu));
    check({tag, "/pc_next_sel"}, 32'(bus.pc_next_sel), 32'(e_nxt));
    check({tag, "/exec_req"}, 32'({bus.mem_req, bus.pc_we}), 0);
    tick;
    check({tag, "/pc_we"}, 32'(bus.pc_we), 1);
    check({tag, "/rd_we"}, 32'(bus.rd_we), 32'(e_rd));
    check({tag, "/wb_pc_alu_sel"}, 32'(bus.pc_alu_sel), 32'(e_alu));
    tick;
    exp_ret = exp_ret + 2'd1;
    check({tag, "/retired"}, 32'(bus.retired), 32'(exp_ret));
    check({tag, "/next_fetch"}, 32'({bus.mem_req, bus.pc_we, bus.rd_we}), 32'b100);
  endtask

  task automatic run_mem(input string tag, input logic [31:0] w, input int cbit,
                         input int mem_waits, input logic e_we, input logic e_rd);
    logic [9:0] c;
    c = 10'(1) << cbit;
    fetch(0, w, c, 1'b0, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < mem_waits; i++) begin
      check({tag, "/mem_ctl"}, 32'({bus.mem_req, bus.addr_sel, bus.mem_we}), 32'({2'b11, e_we}));
      tick;
    end
    bus.mem_ready = 1'b1;
    #1 check({tag, "/mem_last"}, 32'({bus.mem_req, bus.addr_sel, bus.mem_we, bus.insn_we}),
             32'({2'b11, e_we, 1'b0}));
    tick;
    bus.mem_ready = 1'b0;
    check({tag, "/wb_mem"}, 32'({bus.mem_req, bus.addr_sel, bus.mem_we}), 0);
    check({tag, "/wb_we"}, 32'({bus.pc_we, bus.rd_we}), 32'({1'b1, e_rd}));
    tick;
    exp_ret = exp_ret + 2'd1;
    check({tag, "/retired"}, 32'(bus.retired), 32'(exp_ret));
  endtask

  task automatic run_illegal(input string tag, input logic [9:0] c);
    apply_reset();
    fetch(0, 32'h00000033, c, 1'b0, 1'b0, 1'b0);
    check({tag, "/exec_ok"}, 32'(bus.illegal), 0);
    tick;
    check({tag, "/illegal"}, 32'(bus.illegal), 1);
    check({tag, "/halt_strobes"}, 32'({bus.mem_req, bus.pc_we, bus.rd_we, bus.mem_we}), 0);
    bus.mem_ready = 1'b1;
    repeat (3) tick;
    check({tag, "/halt_hold"}, 32'({bus.mem_req, bus.insn_we, bus.pc_we, bus.illegal}), 32'b0001);
    check({tag, "/halt_retired"}, 32'(bus.retired), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // ADD x3,x1,x2 with one fetch wait state
    run_case("add", 1, 32'h002081B3, C_RALU, 0, 0, 0, 0, 0, 0, 1);
    run_mem("lw", 32'h0000A183, C_LOAD, 3, 1'b0, 1'b1);
    run_case("sub",    0, 32'h40000033, C_RALU,   0, 0, 0, 1, 0, 0, 1);
    run_case("srl",    0, 32'h00005033, C_RALU,   0, 0, 0, 0, 0, 0, 1);
    run_case("srai",   0, 32'h40005013, C_IALU,   0, 0, 0, 1, 0, 0, 1);
    run_case("addi30", 0, 32'h40000013, C_IALU,   0, 0, 0, 0, 0, 0, 1);
    run_case("blt_t",  0, 32'h00004063, C_BRANCH, 0, 1, 0, 1, 1, 0, 0);
    run_case("bltu_n", 0, 32'h00006063, C_BRANCH, 0, 1, 0, 1, 0, 0, 0);
    run_case("beq_n",  0, 32'h00000063, C_BRANCH, 0, 0, 0, 1, 0, 0, 0);
    run_case("bne_t",  0, 32'h00001063, C_BRANCH, 0, 0, 0, 1, 1, 0, 0);
    run_case("bge_t",  0, 32'h00005063, C_BRANCH, 0, 0, 0, 1, 1, 0, 0);
    run_case("bgeu_n", 0, 32'h00007063, C_BRANCH, 0, 0, 1, 1, 0, 0, 0);
    run_case("br010",  0, 32'h00002063, C_BRANCH, 1, 1, 1, 1, 0, 0, 0);
    run_case("jal",    0, 32'h0000006F, C_JAL,    0, 0, 0, 0, 1, 0, 1);
    run_case("jalr",   0, 32'h00000067, C_JALR,   0, 0, 0, 0, 0, 1, 1);
    run_case("lui",    0, 32'h000000B7, C_LUI,    0, 0, 0, 0, 0, 0, 1);
    run_case("auipc",  0, 32'h00000097, C_AUIPC,  0, 0, 0, 0, 0, 0, 1);
    run_case("sys",    0, 32'h00000073, C_SYS,    0, 0, 0, 0, 0, 0, 0);
    run_mem("sw", 32'h0020A023, C_STORE, 1, 1'b1, 1'b0);

    // Reset asserted mid-MEM of a store drops the request immediately
    fetch(0, 32'h0020A023, 10'(1) << C_STORE, 1'b0, 1'b0, 1'b0);
    tick;
    check("srst/mem_active", 32'({bus.mem_req, bus.addr_sel, bus.mem_we}), 32'b111);
    #2 rst_n = 1'b0;
    #1 check("srst/mem_drop", 32'({bus.mem_req, bus.addr_sel, bus.mem_we}), 0);
    check("srst/retired", 32'(bus.retired), 0);

    // Fetch timeout: 14 waits still pending, 15th wait times out
    apply_reset();
    bus.mem_ready = 1'b0;
    repeat (14) tick;
    check("to/pending", 32'({bus.mem_req, bus.mem_timeout}), 32'b10);
    tick;
    check("to/timeout", 32'({bus.mem_req, bus.mem_timeout}), 32'b01);
    bus.mem_ready = 1'b1;
    #1 check("to/halt_insn_we", 32'(bus.insn_we), 0);
    repeat (3) tick;
    check("to/halt_hold", 32'({bus.mem_req, bus.pc_we, bus.rd_we, bus.mem_timeout}), 32'b0001);

    // Ready on the limit cycle is accepted
    apply_reset();
    fetch(14, 32'h002081B3, 10'(1) << C_RALU, 1'b0, 1'b0, 1'b0);
    check("to_lim/no_timeout", 32'(bus.mem_timeout), 0);
    tick;
    check("to_lim/wb", 32'({bus.pc_we, bus.rd_we}), 32'b11);
    tick;
    check("to_lim/retired", 32'(bus.retired), 1);

    run_illegal("ill0", 10'h000);
    run_illegal("ill3", 10'h003);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
